fire6_squeeze_mac_bank: RTL and testbench



---
 rtl/fire6_squeeze_mac_bank_pkg.sv | 37 +++
 rtl/fire6_squeeze_mac_bank_mac.sv | 29 ++
 rtl/fire6_squeeze_mac_bank.sv | 68 ++++++
 tb/tb_fire6_squeeze_mac_bank.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire6_squeeze_mac_bank_pkg.sv
// Shared types and constants for the fire6 squeeze MAC bank.
// Bias and LUT ROM contents are constant tables generated here at elaboration.
package fire6_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned FRAC   = 14;
    localparam int unsigned DSP_NO = 64;

    typedef logic signed [WIDTH-1:0] pix_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Negative sums clamp to zero; bits above the Q1.14 window are dropped, no positive saturation.
    function automatic pix_t requant_relu(acc_t s);
        if (s[ACC_W-1]) begin
            return '0;
        end
        return {1'b0, s[FRAC+WIDTH-2:FRAC]};
    endfunction

    // Per-lane bias in accumulator (Q.28) scale.
    function automatic acc_t bias_word(int lane);
        if (lane < 48) begin
            return '0;
        end
        if (lane < 56) begin
            return acc_t'(32'h1000_0000);
        end
        return acc_t'(55 - lane) <<< FRAC;
    endfunction

    // LUT weight ROM word, address-major, lane-minor.
    function automatic pix_t lut_word(int addr, int lane);
        return pix_t'(addr + lane);
    endfunction

endpackage

// File: rtl/fire6_squeeze_mac_bank_mac.sv
// Single-lane multiply-accumulate with end-of-sum restart.
module mac
    import fire6_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic layer_en,
    input  pix_t pix,
    input  pix_t ker,
    output acc_t acc_out
);

    acc_t prod;

    assign prod = acc_t'(pix) * acc_t'(ker);

    // clr restarts the sum, loading the current term if one is present this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_out <= '0;
        end else if (clr) begin
            acc_out <= layer_en ? prod : '0;
        end else if (layer_en) begin
            acc_out <= acc_out + prod;
        end
    end

endmodule

// File: rtl/fire6_squeeze_mac_bank.sv
// Parallel MAC bank for the fire6 squeeze 1x1 conv: LUT/external kernel mux,
// per-lane accumulators and the bias / ReLU / requantize output stage.
module fire6_squeeze_mac_bank #(
    parameter int unsigned DSP_NO    = fire6_pkg::DSP_NO,
    parameter int unsigned LUT_DEPTH = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                layer_en,
    input  logic                                clr,
    input  logic [fire6_pkg::WIDTH-1:0]         pix,
    input  logic [DSP_NO*fire6_pkg::WIDTH-1:0]  ker_ext,
    input  logic                                use_lut,
    input  logic [$clog2(LUT_DEPTH)-1:0]        lut_addr,
    output logic [DSP_NO*fire6_pkg::WIDTH-1:0]  ofm,
    output logic                                ofm_valid
);

    localparam int unsigned W = fire6_pkg::WIDTH;

    fire6_pkg::pix_t lut_q [DSP_NO];
    fire6_pkg::pix_t ker   [DSP_NO];
    fire6_pkg::acc_t acc   [DSP_NO];
    fire6_pkg::pix_t ofm_q [DSP_NO];

    for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
        // Registered, unconditional ROM read: address in cycle t feeds the MAC in t+1.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                lut_q[i] <= '0;
            end else begin
                lut_q[i] <= fire6_pkg::lut_word(int'(lut_addr), i);
            end
        end

        assign ker[i] = use_lut ? lut_q[i] : fire6_pkg::pix_t'(ker_ext[i*W +: W]);

        mac u_mac (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .layer_en (layer_en),
            .pix      (fire6_pkg::pix_t'(pix)),
            .ker      (ker[i]),
            .acc_out  (acc[i])
        );

        assign ofm[i*W +: W] = ofm_q[i];
    end

    // Capture the pre-edge sums on every clr edge; ofm holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ofm_valid <= 1'b0;
            for (int i = 0; i < DSP_NO; i++) begin
                ofm_q[i] <= '0;
            end
        end else begin
            ofm_valid <= clr;
            if (clr) begin
                for (int i = 0; i < DSP_NO; i++) begin
                    ofm_q[i] <= fire6_pkg::requant_relu(acc[i] + fire6_pkg::bias_word(i));
                end
            end
        end
    end

endmodule

// File: tb/tb_fire6_squeeze_mac_bank.sv
// Directed bench for fire6_squeeze_mac_bank with hand-derived expected outputs.
module tb_fire6_squeeze_mac_bank;

    localparam int unsigned N = 64;
    localparam int unsigned VW = N * 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          layer_en = 1'b0;
    logic          clr = 1'b0;
    logic [15:0]   pix = '0;
    logic [VW-1:0] ker_ext = '0;
    logic          use_lut = 1'b0;
    logic [7:0]    lut_addr = '0;
    logic [VW-1:0] ofm;
    logic          ofm_valid;

    int vectors = 0;
    int miscompares = 0;

    fire6_squeeze_mac_bank dut (
        .clk       (clk),
        .rst       (rst),
        .layer_en  (layer_en),
        .clr       (clr),
        .pix       (pix),
        .ker_ext   (ker_ext),
        .use_lut   (use_lut),
        .lut_addr  (lut_addr),
        .ofm       (ofm),
        .ofm_valid (ofm_valid)
    );

    always #5 clk = ~clk;

    // Expected bias table: lanes 0-47 zero, 48-55 +1.0 (Q.28), 56-63 minus 1..8 output LSBs.
    function automatic logic [31:0] bias_of(input int i);
        if (i < 48) return 32'h0000_0000;
        if (i < 56) return 32'h1000_0000;
        return 32'(-((i - 55) * 16384));
    endfunction

    // Expected ofm vector: uniform accumulator base plus optional LUT term (a+i) x 1.0.
    function automatic logic [VW-1:0] expect_ofm(input logic [31:0] base, input int lut_a, input bit lut);
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) begin
            logic [31:0] s;
            s = base + bias_of(i);
            if (lut) s = s + (32'(lut_a + i) << 14);
            v[i*16 +: 16] = s[31] ? 16'h0000 : {1'b0, s[28:14]};
        end
        return v;
    endfunction

    function automatic int first_bad_lane(input logic [VW-1:0] a, input logic [VW-1:0] b);
        for (int i = 0; i < N; i++) begin
            if (a[i*16 +: 16] !== b[i*16 +: 16]) return i;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] exp_v;
        int l;
        rst = 1'b0;
        repeat (2) tick();
        exp_v = '0;
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL reset_ofm lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        vectors++;
        if (ofm_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid got=%b want=0", ofm_valid);
        end
        #2 rst = 1'b1;
        repeat (5) tick();
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL idle_ofm lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        vectors++;
        if (ofm_valid !== 1'b0) begin
            miscompares++; $display("FAIL idle_valid got=%b want=0", ofm_valid);
        end
    endtask

    task automatic test_accumulate();
        logic [VW-1:0] exp_v;
        int l;
        use_lut = 1'b0; ker_ext = {N{16'h4000}}; pix = 16'h2000;
        layer_en = 1'b1; clr = 1'b0;
        repeat (2) tick();
        layer_en = 1'b0; clr = 1'b1;
        tick();
        exp_v = expect_ofm(32'h1000_0000, 0, 1'b0);
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL two_term_ofm lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        vectors++;
        if (ofm_valid !== 1'b1) begin
            miscompares++; $display("FAIL two_term_valid got=%b want=1", ofm_valid);
        end
        clr = 1'b0;
        tick();
        vectors++;
        if (ofm_valid !== 1'b0) begin
            miscompares++; $display("FAIL valid_one_cycle got=%b want=0", ofm_valid);
        end
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL ofm_hold lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
    endtask

    task automatic test_relu();
        logic [VW-1:0] exp_v;
        int l;
        ker_ext = {N{16'hC000}}; pix = 16'h4000;
        layer_en = 1'b1;
        tick();
        layer_en = 1'b0; clr = 1'b1;
        tick();
        exp_v = '0;
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL relu_ofm lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_lut();
        logic [VW-1:0] exp_v;
        int l;
        use_lut = 1'b1; lut_addr = 8'd5; pix = 16'h4000; ker_ext = '0;
        tick();
        layer_en = 1'b1;
        tick();
        layer_en = 1'b0; clr = 1'b1;
        tick();
        exp_v = expect_ofm(32'h0, 5, 1'b1);
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL lut_ofm lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        // New address presented in the same cycle as the term: the stale word is used.
        clr = 1'b0; lut_addr = 8'd3;
        tick();
        lut_addr = 8'd20; layer_en = 1'b1; clr = 1'b1;
        tick();
        exp_v = expect_ofm(32'h0, 0, 1'b0);
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL lut_early_clr lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        layer_en = 1'b0;
        tick();
        exp_v = expect_ofm(32'h0, 3, 1'b1);
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL lut_stale_addr lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        // use_lut toggling between consecutive terms.
        clr = 1'b0; lut_addr = 8'd7;
        tick();
        use_lut = 1'b0; ker_ext = {N{16'h4000}}; layer_en = 1'b1;
        tick();
        use_lut = 1'b1;
        tick();
        layer_en = 1'b0; clr = 1'b1;
        tick();
        exp_v = expect_ofm(32'h1000_0000, 7, 1'b1);
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL lut_toggle lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        clr = 1'b0; use_lut = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] exp_v;
        int l;
        ker_ext = {N{16'h4000}}; pix = 16'h4000; layer_en = 1'b1; clr = 1'b0;
        tick();
        clr = 1'b1;
        exp_v = expect_ofm(32'h1000_0000, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (ofm !== exp_v) begin
                miscompares++; l = first_bad_lane(ofm, exp_v);
                $display("FAIL b2b_ofm%0d lane %0d got=%h want=%h", k, l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
            end
            vectors++;
            if (ofm_valid !== 1'b1) begin
                miscompares++; $display("FAIL b2b_valid%0d got=%b want=1", k, ofm_valid);
            end
        end
        clr = 1'b0; layer_en = 1'b0;
        tick();
        vectors++;
        if (ofm_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_valid_drop got=%b want=0", ofm_valid);
        end
        clr = 1'b1;
        tick();
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL b2b_last_term lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        tick();
        exp_v = expect_ofm(32'h0, 0, 1'b0);
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL bias_only lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic [VW-1:0] exp_v;
        int l;
        ker_ext = {N{16'h7FFF}}; pix = 16'h7FFF; layer_en = 1'b1;
        repeat (2) tick();
        layer_en = 1'b0; clr = 1'b1;
        tick();
        exp_v = expect_ofm(32'h7FFE_0002, 0, 1'b0);
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL discard_bits lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        clr = 1'b0; layer_en = 1'b1;
        repeat (8) tick();
        layer_en = 1'b0; clr = 1'b1;
        tick();
        exp_v = expect_ofm(32'hFFF8_0008, 0, 1'b0);
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL acc_wrap lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] exp_v;
        int l;
        ker_ext = {N{16'h4000}}; pix = 16'h4000; layer_en = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        exp_v = expect_ofm(32'h1000_0000, 0, 1'b0);
        vectors++;
        if (ofm !== exp_v || ofm_valid !== 1'b1) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL pre_reset lane %0d got=%h want=%h valid=%b", l, ofm[l*16 +: 16], exp_v[l*16 +: 16], ofm_valid);
        end
        #2 rst = 1'b0;
        #1;
        exp_v = '0;
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL async_reset_ofm lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        vectors++;
        if (ofm_valid !== 1'b0) begin
            miscompares++; $display("FAIL async_reset_valid got=%b want=0", ofm_valid);
        end
        clr = 1'b0; layer_en = 1'b0;
        tick();
        rst = 1'b1;
        clr = 1'b1;
        tick();
        exp_v = expect_ofm(32'h0, 0, 1'b0);
        vectors++;
        if (ofm !== exp_v) begin
            miscompares++; l = first_bad_lane(ofm, exp_v);
            $display("FAIL post_reset_acc lane %0d got=%h want=%h", l, ofm[l*16 +: 16], exp_v[l*16 +: 16]);
        end
        clr = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_relu();
        test_lut();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
